mainfsm: RTL and testbench

Multicycle main control FSM for the MIPS core. It decodes the 6-bit opcode across several cycles and sequences the shared datapath (one memory port, one ALU, IR, PC) through fetch, decode, execute, memory and writeback. A memory-ready handshake stretches the cycles that touch memory. It supports the RTYPE, LW, SW, BEQ, ADDI and J opcodes, and flags illegal opcodes.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mainfsm.sv | 129 ++++++++++++
 tb/tb_mainfsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM states and datapath control encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, ILLEGAL
  } statetype;

endpackage

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle MIPS main control FSM
module mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);

  statetype state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (memready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (memready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
      ILLEGAL: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    pcsrc    = PCSRC_ALU;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    aluop    = ALUOP_ADD;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      FETCH: begin
        // IR and PC load only in the cycle the read data is actually valid
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE:  alusrcb = SRCB_IMMSH;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - scoreboard bench for mainfsm
module tb_mainfsm;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t v;
    string name;
  } exp_t;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3, T_MEMWB = 4,
                 T_MEMWR = 5, T_RTEX = 6, T_RTWB = 7, T_BEQ = 8, T_ADDIEX = 9,
                 T_ADDIWB = 10, T_JEX = 11, T_ILL = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  outs_t      act;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memread(act.memread), .memwrite(act.memwrite), .iord(act.iord),
    .irwrite(act.irwrite), .pcwrite(act.pcwrite), .branch(act.branch),
    .pcsrc(act.pcsrc), .alusrca(act.alusrca), .alusrcb(act.alusrcb),
    .aluop(act.aluop), .regdst(act.regdst), .memtoreg(act.memtoreg),
    .regwrite(act.regwrite), .illegal(act.illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t expect_of(input int st, input logic mr);
    exp_t e;
    e.v = '0;
    case (st)
      T_FETCH:  begin e.name = "FETCH";   e.v.memread = 1; e.v.alusrcb = 2'b01;
                      e.v.irwrite = mr; e.v.pcwrite = mr; end
      T_DECODE: begin e.name = "DECODE";  e.v.alusrcb = 2'b11; end
      T_MEMADR: begin e.name = "MEMADR";  e.v.alusrca = 1; e.v.alusrcb = 2'b10; end
      T_MEMRD:  begin e.name = "MEMRD";   e.v.iord = 1; e.v.memread = 1; end
      T_MEMWB:  begin e.name = "MEMWB";   e.v.memtoreg = 1; e.v.regwrite = 1; end
      T_MEMWR:  begin e.name = "MEMWR";   e.v.iord = 1; e.v.memwrite = 1; end
      T_RTEX:   begin e.name = "RTYPEEX"; e.v.alusrca = 1; e.v.aluop = 2'b10; end
      T_RTWB:   begin e.name = "RTYPEWB"; e.v.regdst = 1; e.v.regwrite = 1; end
      T_BEQ:    begin e.name = "BEQEX";   e.v.alusrca = 1; e.v.aluop = 2'b01;
                      e.v.pcsrc = 2'b01; e.v.branch = 1; end
      T_ADDIEX: begin e.name = "ADDIEX";  e.v.alusrca = 1; e.v.alusrcb = 2'b10; end
      T_ADDIWB: begin e.name = "ADDIWB";  e.v.regwrite = 1; end
      T_JEX:    begin e.name = "JEX";     e.v.pcsrc = 2'b10; e.v.pcwrite = 1; end
      default:  begin e.name = "ILLEGAL"; e.v.illegal = 1; end
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge, queue what the outputs must be
  task automatic cyc(input logic [5:0] o, input logic mr, input int st, input logic rst = 1'b0);
    @(posedge clk);
    #1;
    reset    = rst;
    op       = o;
    memready = mr;
    sb.push_back(expect_of(st, mr));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b (t=%0t)", e.name, act, e.v, $time);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; op = 6'b0; memready = 1'b1;
    // reset state, then RTYPE
    cyc(6'h00, 1, T_FETCH, 1);
    cyc(6'h00, 1, T_FETCH);
    cyc(6'h00, 1, T_DECODE);
    cyc(6'h3f, 1, T_RTEX);
    cyc(6'h23, 1, T_RTWB);
    cyc(6'h00, 1, T_FETCH);
    // LW with two wait cycles; op changes in MEMRD are ignored
    cyc(6'h23, 1, T_DECODE);
    cyc(6'h23, 1, T_MEMADR);
    cyc(6'h3f, 0, T_MEMRD);
    cyc(6'h2b, 0, T_MEMRD);
    cyc(6'h00, 1, T_MEMRD);
    cyc(6'h00, 1, T_MEMWB);
    cyc(6'h00, 1, T_FETCH);
    // SW with three wait cycles
    cyc(6'h2b, 1, T_DECODE);
    cyc(6'h2b, 1, T_MEMADR);
    cyc(6'h23, 0, T_MEMWR);
    cyc(6'h23, 0, T_MEMWR);
    cyc(6'h00, 0, T_MEMWR);
    cyc(6'h00, 1, T_MEMWR);
    cyc(6'h00, 1, T_FETCH);
    // SW interrupted by reset mid-wait
    cyc(6'h2b, 1, T_DECODE);
    cyc(6'h2b, 1, T_MEMADR);
    cyc(6'h2b, 0, T_MEMWR);
    cyc(6'h2b, 0, T_FETCH, 1);
    cyc(6'h2b, 1, T_FETCH, 1);
    cyc(6'h04, 1, T_FETCH);
    // BEQ
    cyc(6'h04, 1, T_DECODE);
    cyc(6'h04, 1, T_BEQ);
    cyc(6'h02, 1, T_FETCH);
    // J
    cyc(6'h02, 1, T_DECODE);
    cyc(6'h02, 1, T_JEX);
    cyc(6'h3f, 1, T_FETCH);
    // illegal opcode: one-cycle pulse
    cyc(6'h3f, 1, T_DECODE);
    cyc(6'h3f, 1, T_ILL);
    cyc(6'h3f, 0, T_FETCH);
    // FETCH stretched by memready low, then ADDI
    cyc(6'h3f, 0, T_FETCH);
    cyc(6'h3f, 0, T_FETCH);
    cyc(6'h3f, 0, T_FETCH);
    cyc(6'h3f, 0, T_FETCH);
    cyc(6'h08, 1, T_FETCH);
    cyc(6'h08, 1, T_DECODE);
    cyc(6'h08, 1, T_ADDIEX);
    cyc(6'h08, 1, T_ADDIWB);
    cyc(6'h08, 1, T_FETCH);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
